hex_display_mux: RTL and testbench

Parametrised, time-multiplexed hex driver for a common-anode multi-digit seven-segment display. It latches a DIGITS-nibble value, scans one digit per refresh slot and drives shared active-low segment and decimal-point lines plus active-low digit enables. It adds leading-zero suppression, per-digit decimal points, per-digit blinking and anti-ghosting dead time. It sits between the ALU result register and the board display pins.

---
 rtl/hex_display_mux.sv | 83 ++++++++
 tb/tb_hex_display_mux.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed seven-segment hex driver with leading-zero
// suppression, per-digit decimal points, blinking and one dark cycle per slot.
module hex_display_mux #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [6:0]            segment,
    output logic                  dp,
    output logic [DIGITS-1:0]     digit_sel
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    // Glyph for nibble n lives at bits [7n +: 7], active-low, bit6=g .. bit0=a
    localparam logic [111:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    logic [4*DIGITS-1:0] shadow_q, shadow_d, upper;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                phase_q, phase_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                slot_end, frame_end, wrap, dark, blank;
    logic [3:0]          nib;

    always_comb begin
        slot_end  = cnt_q == CW'(REFRESH_DIV - 1);
        frame_end = slot_end && idx_q == IW'(DIGITS - 1);
        wrap      = frame_end && frame_q == FW'(BLINK_FRAMES - 1);
        shadow_d  = load ? value : shadow_q;
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = frame_end ? '0 : slot_end ? idx_q + IW'(1) : idx_q;
        frame_d   = wrap ? '0 : frame_end ? frame_q + FW'(1) : frame_q;
        phase_d   = phase_q ^ wrap;
        // Everything above and including the current digit; zero means a leading zero
        upper     = shadow_q >> {idx_q, 2'b00};
        nib       = upper[3:0];
        blank     = (lz_en && idx_q != '0 && upper == '0) || (blink_en[idx_q] && phase_q);
        dark      = cnt_q == '0;
        sel_d     = dark ? '1 : ~(DIGITS'(1) << idx_q);
        seg_d     = (dark || blank) ? 7'h7F : GLYPHS[7*int'(nib) +: 7];
        dp_d      = dark || blank || !dp_in[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            phase_q  <= 1'b0;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            sel_q    <= '1;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            sel_q    <= sel_d;
        end
    end

    assign segment   = seg_q;
    assign dp        = dp_q;
    assign digit_sel = sel_q;
endmodule

// File: tb/tb_hex_display_mux.sv
// tb_hex_display_mux: directed and random stimulus checked against a
// time-indexed arithmetic model of the scanned display.
module tb_hex_display_mux;
    localparam int D  = 4;
    localparam int R  = 4;
    localparam int BF = 2;

    logic        clk, rst_n, load, lz_en, dp;
    logic [15:0] value;
    logic [3:0]  dp_in, blink_en, digit_sel;
    logic [6:0]  segment;

    int          errors = 0;
    int          checks = 0;
    int          t = 0;
    logic [15:0] sh = '0;
    logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_display_mux #(.DIGITS(D), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lz_en(lz_en),
        .dp_in(dp_in), .blink_en(blink_en), .segment(segment), .dp(dp),
        .digit_sel(digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {digit_sel, segment, dp} after an edge taken t cycles into the scan
    function automatic logic [11:0] model_out(int tt, logic [15:0] s, logic lz,
                                              logic [3:0] dpi, logic [3:0] ben);
        int  cnt   = tt % R;
        int  di    = (tt / R) % D;
        int  ph    = (tt / (R * D) / BF) % 2;
        int  above = int'(s) / (1 << (4 * di));
        int  nv    = above % 16;
        logic blk  = (lz && di > 0 && above == 0) || (ben[di] && ph == 1);
        logic [3:0] sel = 4'hF;
        if (cnt == 0) return {4'hF, 7'h7F, 1'b1};
        sel[di] = 1'b0;
        return {sel, blk ? 7'h7F : glyph[nv], blk ? 1'b1 : ~dpi[di]};
    endfunction

    task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, t);
        end
    endtask

    task automatic step();
        logic [11:0] e;
        e = rst_n ? model_out(t, sh, lz_en, dp_in, blink_en) : {4'hF, 7'h7F, 1'b1};
        @(posedge clk);
        if (!rst_n) begin
            t  = 0;
            sh = '0;
        end else begin
            t++;
            if (load) sh = value;
        end
        #1;
        chk("digit_sel", 7'(digit_sel), 7'(e[11:8]));
        chk("segment", segment, e[7:1]);
        chk("dp", 7'(dp), 7'(e[0]));
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; value = '0; lz_en = 1'b0; dp_in = '0; blink_en = '0;
        repeat (2) step();
        chk("rst_seg", segment, 7'h7F);
        chk("rst_sel", 7'(digit_sel), 7'hF);
        rst_n = 1'b1; load = 1'b1; value = 16'h12AF;
        step();
        chk("first_dark", 7'(digit_sel), 7'hF);
        load = 1'b0;
        step();
        chk("first_sel", 7'(digit_sel), 7'hE);
        chk("first_seg", segment, 7'h0E);
        repeat (30) step();
        value = 16'h0050; load = 1'b1; lz_en = 1'b1;
        step();
        load = 1'b0;
        repeat (20) step();
        lz_en = 1'b0;
        repeat (20) step();
        value = 16'h0000; load = 1'b1; lz_en = 1'b1; dp_in = 4'b0100;
        step();
        load = 1'b0;
        repeat (20) step();
        dp_in = 4'b0101;
        repeat (16) step();
        dp_in = '0; lz_en = 1'b0;
        value = 16'h1234; load = 1'b1; blink_en = 4'b0001;
        step();
        load = 1'b0;
        repeat (100) step();
        blink_en = '0;
        for (int i = 0; i < 16 && (t % 16) != 6; i++) step();
        value = 16'hBEEF; load = 1'b1;
        step();
        load = 1'b0; value = 16'h5555;
        repeat (20) step();
        repeat (400) begin
            value = 16'($urandom);
            load = ($urandom_range(0, 7) == 0);
            lz_en = 1'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blink_en = 4'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1; load = 1'b1; value = 16'h9876;
        step();
        load = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        chk("midrst_seg", segment, 7'h7F);
        chk("midrst_sel", 7'(digit_sel), 7'hF);
        rst_n = 1'b1; lz_en = 1'b0; blink_en = '0;
        repeat (2) step();
        chk("after_rst_sel", 7'(digit_sel), 7'hE);
        chk("after_rst_seg", segment, 7'h40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
